unos_broja: RTL

UNOS_BROJA -- requirements
Module: unos_broja

---
 rtl/unos_broja.sv | 139 +++++++++++++
 1 files changed

// File: rtl/unos_broja.sv
// PS/2 scan-code front end that collects up to two decimal digit make codes and
// latches them as a tens/units pair on Enter. Optional macro: UNOS_BACKSPACE_EN (Backspace/Esc editing).
module unos_broja (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_done_tick,
    output logic [7:0] key_code_1,
    output logic [7:0] key_code_2,
    output logic       broj_spreman,
    output logic [1:0] broj_cifara
);

    localparam logic [7:0] CODE_ZERO  = 8'h45;
    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CODE_ESC   = 8'h76;

    // Make codes for keys 0..9, key 0 in the lowest byte.
    localparam logic [79:0] DIGIT_CODES = {
        8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
    };

    typedef enum logic [1:0] {
        CEKA      = 2'd0,
        BREAK     = 2'd1,
        EXT       = 2'd2,
        EXT_BREAK = 2'd3
    } state_t;

    state_t     state_reg;
    logic [1:0] cnt_reg;
    logic [7:0] slot_reg [2];
    logic [7:0] kc1_reg;
    logic [7:0] kc2_reg;
    logic       ready_reg;

    logic [9:0] digit_hit;
    logic       is_digit;
    logic       key_event;
    logic       do_enter;
    logic       do_digit;
    logic       do_back;
    logic       do_esc;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_digit
            assign digit_hit[gi] = (scan_code == DIGIT_CODES[gi*8 +: 8]);
        end
    endgenerate

    assign is_digit = |digit_hit;

    // A plain key byte is any byte seen in CEKA that is not a prefix.
    assign key_event = scan_done_tick && (state_reg == CEKA)
                       && (scan_code != CODE_BREAK) && (scan_code != CODE_EXT);

    assign do_enter = scan_done_tick && (scan_code == CODE_ENTER)
                      && ((state_reg == CEKA) || (state_reg == EXT));
    assign do_digit = key_event && is_digit && (cnt_reg < 2'd2);

`ifdef UNOS_BACKSPACE_EN
    assign do_back = key_event && (scan_code == CODE_BKSP) && (cnt_reg != 2'd0);
    assign do_esc  = key_event && (scan_code == CODE_ESC);
`else
    assign do_back = 1'b0;
    assign do_esc  = 1'b0;
    logic unused_edit_codes;
    assign unused_edit_codes = ^{CODE_BKSP, CODE_ESC};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= CEKA;
            cnt_reg     <= 2'd0;
            slot_reg[0] <= CODE_ZERO;
            slot_reg[1] <= CODE_ZERO;
            kc1_reg     <= CODE_ZERO;
            kc2_reg     <= CODE_ZERO;
            ready_reg   <= 1'b0;
        end else begin
            ready_reg <= do_enter;

            if (scan_done_tick) begin
                case (state_reg)
                    CEKA: begin
                        if (scan_code == CODE_BREAK)
                            state_reg <= BREAK;
                        else if (scan_code == CODE_EXT)
                            state_reg <= EXT;
                        else
                            state_reg <= CEKA;
                    end
                    EXT: begin
                        if (scan_code == CODE_BREAK)
                            state_reg <= EXT_BREAK;
                        else
                            state_reg <= CEKA;
                    end
                    default: state_reg <= CEKA;
                endcase
            end

            // Missing leading digits are padded with the make code of key 0.
            if (do_enter) begin
                cnt_reg <= 2'd0;
                case (cnt_reg)
                    2'd0: begin
                        kc1_reg <= CODE_ZERO;
                        kc2_reg <= CODE_ZERO;
                    end
                    2'd1: begin
                        kc1_reg <= CODE_ZERO;
                        kc2_reg <= slot_reg[0];
                    end
                    default: begin
                        kc1_reg <= slot_reg[0];
                        kc2_reg <= slot_reg[1];
                    end
                endcase
            end else if (do_digit) begin
                slot_reg[cnt_reg[0]] <= scan_code;
                cnt_reg              <= cnt_reg + 2'd1;
            end else if (do_back) begin
                cnt_reg <= cnt_reg - 2'd1;
            end else if (do_esc) begin
                cnt_reg <= 2'd0;
            end
        end
    end

    assign key_code_1   = kc1_reg;
    assign key_code_2   = kc2_reg;
    assign broj_spreman = ready_reg;
    assign broj_cifara  = cnt_reg;

endmodule
